button_event_gen: RTL and testbench
===================================

# button_event_gen

Turns a debounced, clean push-button level into single-cycle action pulses for the game controller: press, release, and (optionally) timed auto-repeat while the button is held. It sits between each debouncer output and the game FSM's cursor/fire inputs, one instance per button. All logic runs in the system clock domain. It contains a synchronous lockout so that a button already down at reset never fires.

## Interface
- `HOLD_CYCLES`, default 50_000_000: clocks the button must stay held after the press pulse before the first repeat (500 ms at 100 MHz); legal range ≥ 1.
- `REPEAT_CYCLES`, default 10_000_000: clocks between successive repeat pulses (100 ms); legal range ≥ 1.
- `CNT_W`, default `$clog2(max(HOLD_CYCLES,REPEAT_CYCLES))+1`: hold/repeat counter width; not overridden by users.
- `clk`  input  1  system clock (100 MHz), all state on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `btn`  input  1  debounced button level, 1 = pressed; synchronous to `clk` edges.
- `press`  output  1  one-cycle pulse on accepted press.
- `release_p`  output  1  one-cycle pulse on release after an accepted press.
- `repeat_p`  output  1  one-cycle auto-repeat pulse.
- `held`  output  1  level, high while the FSM is in PRESSED or REPEAT.

## Operation
- Input register `btn_q` samples `btn` every clock; reset value 1. The FSM acts only on `btn_q`.
- Hold/repeat counter `cnt[CNT_W-1:0]`, reset 0.
- States: LOCKOUT (reset state), IDLE, PRESSED, REPEAT. All outputs are registered; the reset value of every output is 0.
- LOCKOUT: `btn_q`=0 -> IDLE. Otherwise stay. No outputs are produced.
- IDLE: `btn_q`=1 -> PRESSED, `press`<=1, `cnt`<=0.
- PRESSED:
  - `btn_q`=0 -> IDLE, `release_p`<=1.
  - Else if `cnt`==HOLD_CYCLES-1 -> REPEAT, `repeat_p`<=1, `cnt`<=0.
  - Else `cnt`++.
- REPEAT:
  - `btn_q`=0 -> IDLE, `release_p`<=1.
  - Else if `cnt`==REPEAT_CYCLES-1 -> `repeat_p`<=1, `cnt`<=0.
  - Else `cnt`++.
- Priority: release beats a repeat terminal count in the same cycle. At most one of `press`, `release_p` and `repeat_p` is high in any cycle.
- `held` <= 1 on entering PRESSED, and <= 0 on returning to IDLE.
- Counter never wraps. It is compared against the terminal value and cleared, so width overflow is impossible for legal parameters.

## Timing
- Press latency: `btn` sampled high at edge k. `press` is high for exactly one cycle, in the cycle following edge k+1.
- First repeat: `repeat_p` rises at edge k+1+HOLD_CYCLES (counted from the press edge) if `btn` stays high.
- Subsequent repeats: every REPEAT_CYCLES clocks.
- Release latency: `btn` sampled low at edge m -> `release_p` high in the cycle after edge m+1. `held` falls on the same edge.
- Reset out of LOCKOUT, button up: the first clock with `rst_n`=1 loads `btn_q`=0, and the next clock enters IDLE. The earliest possible press pulse is therefore 3 edges after reset release.
- Reset mid-press: all outputs 0 on the next edge, state LOCKOUT. No `release_p` is emitted, and no `press` is emitted until `btn` is seen low and then high again.
- Minimum press: a 1-cycle high on `btn` yields `press` and then `release_p` on consecutive cycles.

## Configuration
- `BTN_REPEAT_EN`:
  - Defined: full behaviour above.
  - Undefined: the REPEAT state and terminal-count logic are not compiled. PRESSED stays until release, `cnt` is removed, and `repeat_p` is tied to 0. `press`, `release_p`, `held` and the lockout are unchanged.

## Test plan
- Lockout (HOLD_CYCLES=8, REPEAT_CYCLES=4): hold `btn`=1 through reset and 20 clocks after -> `press`, `repeat_p` and `held` all stay 0. Then drop `btn` for 2 clocks and raise it -> exactly one `press`, 2 edges after the rise.
- Short press (same parameters): `btn` high for 3 clocks -> one `press`, `held` high for 3 cycles, one `release_p`, no `repeat_p`.
- Auto-repeat (same parameters): hold `btn` for 30 clocks after the press -> `repeat_p` pulses at press-edge+8, +12, +16, +20, +24, +28 (relative to the press edge). Then one `release_p`.
- Release/repeat collision: drop `btn` so that `btn_q`=0 on the repeat terminal-count cycle -> `release_p`=1, `repeat_p`=0, state IDLE.
- Reset mid-repeat: assert `rst_n`=0 for 1 clock while in REPEAT -> all outputs 0 next edge, no `release_p`, and re-arming requires `btn` low.
- `BTN_REPEAT_EN` undefined: 30-clock hold -> one `press`, zero `repeat_p`, one `release_p`.

Source files
------------

// File: rtl/button_event_gen_if.sv
// button_event_gen_if: button level in, press/release/repeat pulses and held level out.
interface button_event_gen_if;
  logic btn;
  logic press;
  logic release_p;
  logic repeat_p;
  logic held;
  modport master (output btn, input press, release_p, repeat_p, held);
  modport slave (input btn, output press, release_p, repeat_p, held);
endinterface

// File: rtl/button_event_gen.sv
// button_event_gen: clean button level to press/release pulses with reset lockout.
// Auto-repeat (REPEAT state, hold/repeat counter) is compiled only with `BTN_REPEAT_EN.
module button_event_gen #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1
) (
  input logic clk,
  input logic rst_n,
  button_event_gen_if.slave bus
);
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
    $error("button_event_gen: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end
`ifdef BTN_REPEAT_EN
  typedef enum logic [1:0] {LOCKOUT, IDLE, PRESSED, REPEAT} state_e;
`else
  typedef enum logic [1:0] {LOCKOUT, IDLE, PRESSED} state_e;
`endif
  state_e state_q, state_d;
  logic btn_q;
  logic press_q, press_d;
  logic release_q, release_d;
  logic held_q, held_d;
`ifdef BTN_REPEAT_EN
  logic repeat_q, repeat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif
  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    release_d = 1'b0;
`ifdef BTN_REPEAT_EN
    repeat_d = 1'b0;
    cnt_d = cnt_q;
`endif
    case (state_q)
      LOCKOUT: state_d = btn_q ? LOCKOUT : IDLE;
      IDLE: begin
        if (btn_q) begin
          state_d = PRESSED;
          press_d = 1'b1;
`ifdef BTN_REPEAT_EN
          cnt_d = '0;
`endif
        end
      end
      PRESSED: begin
        if (!btn_q) begin
          state_d = IDLE;
          release_d = 1'b1;
        end
`ifdef BTN_REPEAT_EN
        else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = REPEAT;
          repeat_d = 1'b1;
          cnt_d = '0;
        end else cnt_d = cnt_q + 1'b1;
`endif
      end
`ifdef BTN_REPEAT_EN
      REPEAT: begin
        // release wins over a coincident terminal count
        if (!btn_q) begin
          state_d = IDLE;
          release_d = 1'b1;
        end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
          repeat_d = 1'b1;
          cnt_d = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
`endif
      default: state_d = LOCKOUT;
    endcase
`ifdef BTN_REPEAT_EN
    held_d = (state_d == PRESSED) || (state_d == REPEAT);
`else
    held_d = state_d == PRESSED;
`endif
  end
  // btn_q resets high so a button already down at reset is held off in LOCKOUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOCKOUT;
      btn_q <= 1'b1;
      press_q <= 1'b0;
      release_q <= 1'b0;
      held_q <= 1'b0;
`ifdef BTN_REPEAT_EN
      repeat_q <= 1'b0;
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      btn_q <= bus.btn;
      press_q <= press_d;
      release_q <= release_d;
      held_q <= held_d;
`ifdef BTN_REPEAT_EN
      repeat_q <= repeat_d;
      cnt_q <= cnt_d;
`endif
    end
  end
  assign bus.press = press_q;
  assign bus.release_p = release_q;
  assign bus.held = held_q;
`ifdef BTN_REPEAT_EN
  assign bus.repeat_p = repeat_q;
`else
  assign bus.repeat_p = 1'b0;
`endif
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: scoreboard bench; expected pulse cycles are queued as the button is driven.
module tb_button_event_gen;
  localparam int HOLD = 8;
  localparam int REP = 4;
  localparam logic [2:0] EV_PRESS = 3'b100;
  localparam logic [2:0] EV_REL = 3'b010;
  localparam logic [2:0] EV_REP = 3'b001;
  typedef struct {
    int at;
    logic [2:0] kind;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int held_cnt = 0;
  ev_t q[$];
  button_event_gen_if bif ();
  button_event_gen #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic push(input int at, input logic [2:0] kind);
    ev_t e;
    e.at = at;
    e.kind = kind;
    q.push_back(e);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  // btn driven high at cycle c: press at c+2, release at c+n+2, repeats while btn_q still high
  task automatic press_hold(input int n);
    int c;
    c = cyc;
    held_cnt = 0;
    bif.btn = 1'b1;
    push(c + 2, EV_PRESS);
`ifdef BTN_REPEAT_EN
    for (int t = c + 2 + HOLD; t <= c + n + 1; t += REP) push(t, EV_REP);
`endif
    push(c + n + 2, EV_REL);
    tick(n);
    bif.btn = 1'b0;
    tick(4);
    chk("held_len", held_cnt, n);
  endtask
  always @(negedge clk) begin
    logic [2:0] k;
    ev_t e;
    k = {bif.press, bif.release_p, bif.repeat_p};
    if (bif.held) held_cnt++;
    if (k != 3'b000) begin
      if (q.size() == 0) chk("unexpected_pulse", k, 3'b000);
      else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.at);
        chk("pulse_kind", k, e.kind);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c;
    bif.btn = 1'b1;
    tick(3);
    chk("rst_press", bif.press, 0);
    chk("rst_release", bif.release_p, 0);
    chk("rst_repeat", bif.repeat_p, 0);
    chk("rst_held", bif.held, 0);
    rst_n = 1'b1;
    held_cnt = 0;
    tick(20);
    chk("lockout_held", held_cnt, 0);
    bif.btn = 1'b0;
    tick(2);
    press_hold(3);
    press_hold(30);
    press_hold(12);
    chk("collision_idle_held", bif.held, 0);
    c = cyc;
    bif.btn = 1'b1;
    push(c + 2, EV_PRESS);
`ifdef BTN_REPEAT_EN
    push(c + 2 + HOLD, EV_REP);
    push(c + 2 + HOLD + REP, EV_REP);
`endif
    tick(14);
    chk("held_pre_rst", bif.held, 1);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_press", bif.press, 0);
    chk("midrst_release", bif.release_p, 0);
    chk("midrst_repeat", bif.repeat_p, 0);
    chk("midrst_held", bif.held, 0);
    rst_n = 1'b1;
    held_cnt = 0;
    tick(20);
    chk("rearm_lockout_held", held_cnt, 0);
    bif.btn = 1'b0;
    tick(4);
    press_hold(2);
    press_hold(1);
    tick(5);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
